// File: rtl/multi_cpu_debug_pkg.sv
// Shared types and constants for the multi-core debug halt controller.
// The optional HALT_LATENCY_STATS_EN build adds halt latency capture in the top.
package multi_cpu_debug_pkg;

  localparam int N_CPU_MAX       = 16;
  localparam int ACK_TIMEOUT_DEF = 2000;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_HALT_WAIT   = 3'd1,
    ST_HALTED      = 3'd2,
    ST_RESUME_WAIT = 3'd3,
    ST_ERROR       = 3'd4
  } halt_state_e;

endpackage

// File: rtl/debug_ack_timeout_cnt.sv
// Clearable, enabled, saturating cycle counter with a terminal-count flag.
// Shared by the halt and resume acknowledge waits.
module debug_ack_timeout_cnt
  import multi_cpu_debug_pkg::*;
#(
  parameter int CNT_W = 12,
  parameter int TERM  = ACK_TIMEOUT_DEF - 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_term
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TERM);

  logic [CNT_W-1:0] r_cnt;

  // Count while enabled, parking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1'b1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt >= CNT_TERM);

endmodule

// File: rtl/multi_cpu_debug_halt_ctrl.sv
// Coordinated halt/resume of N cores over debugreq/debugack with ack timeout.
// Define HALT_LATENCY_STATS_EN to capture cycles from halt start to all_halted.
module multi_cpu_debug_halt_ctrl
  import multi_cpu_debug_pkg::*;
#(
  parameter int N_CPU       = 4,
  parameter int CNT_W       = 12,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic [N_CPU-1:0] cpu_mask,
  input  logic [N_CPU-1:0] debugack,
  output logic [N_CPU-1:0] debugreq,
  output logic             busy,
  output logic             all_halted,
  output logic             timeout_err,
  output logic [N_CPU-1:0] late_mask,
  output logic [CNT_W-1:0] halt_latency
);

  localparam logic [N_CPU-1:0] MASK_ZERO = {N_CPU{1'b0}};

  halt_state_e      r_state, w_state_nxt;
  logic [N_CPU-1:0] r_mask, w_mask_nxt;
  logic [N_CPU-1:0] r_debugreq, w_debugreq_nxt;
  logic [N_CPU-1:0] r_late_mask, w_late_nxt;
  logic             r_busy, r_all_halted, w_all_halted_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;
  logic             w_start, w_cnt_clr, w_cnt_en, w_cnt_term;
  logic             w_acked_all, w_acked_none;
  logic [CNT_W-1:0] w_cnt;

  // Unmasked cores never influence these, so spurious acks are harmless.
  assign w_acked_all  = ((debugack & r_mask) == r_mask);
  assign w_acked_none = ((debugack & r_mask) == MASK_ZERO);
  assign w_cnt_en     = (r_state == ST_HALT_WAIT) || (r_state == ST_RESUME_WAIT);
  assign w_start      = halt_req && ((r_state == ST_IDLE) ||
                                     ((r_state == ST_ERROR) && !resume_req));

  debug_ack_timeout_cnt #(
    .CNT_W (CNT_W),
    .TERM  (ACK_TIMEOUT - 1)
  ) u_ack_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_cnt   (w_cnt),
    .o_term  (w_cnt_term)
  );

  // FSM and output-register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_mask        <= MASK_ZERO;
      r_debugreq    <= MASK_ZERO;
      r_late_mask   <= MASK_ZERO;
      r_busy        <= 1'b0;
      r_all_halted  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mask        <= w_mask_nxt;
      r_debugreq    <= w_debugreq_nxt;
      r_late_mask   <= w_late_nxt;
      r_busy        <= (w_state_nxt == ST_HALT_WAIT) || (w_state_nxt == ST_RESUME_WAIT);
      r_all_halted  <= w_all_halted_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // Next-state and next-output decode; a new halt overrides every other branch.
  always_comb begin
    w_state_nxt       = r_state;
    w_mask_nxt        = r_mask;
    w_debugreq_nxt    = r_debugreq;
    w_late_nxt        = r_late_mask;
    w_all_halted_nxt  = r_all_halted;
    w_timeout_err_nxt = r_timeout_err;
    w_cnt_clr         = 1'b0;

    if (w_start) begin
      w_mask_nxt        = cpu_mask;
      w_cnt_clr         = 1'b1;
      w_timeout_err_nxt = 1'b0;
      w_late_nxt        = MASK_ZERO;
      if (cpu_mask == MASK_ZERO) begin
        w_state_nxt      = ST_HALTED;
        w_debugreq_nxt   = MASK_ZERO;
        w_all_halted_nxt = 1'b1;
      end else begin
        w_state_nxt      = ST_HALT_WAIT;
        w_debugreq_nxt   = cpu_mask;
        w_all_halted_nxt = 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_debugreq_nxt = MASK_ZERO;
        end
        ST_HALT_WAIT: begin
          if (w_acked_all) begin
            w_state_nxt      = ST_HALTED;
            w_all_halted_nxt = 1'b1;
          end else if (w_cnt_term) begin
            w_state_nxt       = ST_ERROR;
            w_late_nxt        = r_mask & ~debugack;
            w_debugreq_nxt    = r_mask & debugack;
            w_timeout_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_HALT_WAIT;
          end
        end
        ST_HALTED, ST_ERROR: begin
          if (resume_req) begin
            w_state_nxt      = ST_RESUME_WAIT;
            w_debugreq_nxt   = MASK_ZERO;
            w_all_halted_nxt = 1'b0;
            w_cnt_clr        = 1'b1;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_RESUME_WAIT: begin
          if (w_acked_none) begin
            w_state_nxt = ST_IDLE;
          end else if (w_cnt_term) begin
            w_state_nxt       = ST_IDLE;
            w_timeout_err_nxt = 1'b1;
            w_late_nxt        = debugack & r_mask;
          end else begin
            w_state_nxt = ST_RESUME_WAIT;
          end
        end
        default: begin
          w_state_nxt      = ST_IDLE;
          w_debugreq_nxt   = MASK_ZERO;
          w_all_halted_nxt = 1'b0;
        end
      endcase
    end
  end

  assign debugreq    = r_debugreq;
  assign busy        = r_busy;
  assign all_halted  = r_all_halted;
  assign timeout_err = r_timeout_err;
  assign late_mask   = r_late_mask;

`ifdef HALT_LATENCY_STATS_EN
  logic [CNT_W-1:0] r_halt_latency;
  logic             w_lat_cap, w_lat_to;

  assign w_lat_cap = (r_state == ST_HALT_WAIT) && w_acked_all;
  assign w_lat_to  = (r_state == ST_HALT_WAIT) && !w_acked_all && w_cnt_term;

  // Latency snapshot: cleared by each accepted halt, set when the halt wait ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_halt_latency <= {CNT_W{1'b0}};
    end else if (w_start) begin
      r_halt_latency <= {CNT_W{1'b0}};
    end else if (w_lat_cap) begin
      r_halt_latency <= w_cnt;
    end else if (w_lat_to) begin
      r_halt_latency <= CNT_W'(ACK_TIMEOUT);
    end else begin
      r_halt_latency <= r_halt_latency;
    end
  end

  assign halt_latency = r_halt_latency;
`else
  logic w_unused_cnt;

  assign w_unused_cnt = ^w_cnt;
  assign halt_latency = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multi_cpu_debug_halt_ctrl.sv
// Scoreboard bench: expected output snapshots are queued with a target cycle
// while stimulus is driven, and compared on the falling edge of that cycle.
module tb_multi_cpu_debug_halt_ctrl;

`ifdef HALT_LATENCY_STATS_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  localparam int N_CPU = 4;
  localparam int CNT_W = 12;
  localparam int TMO   = 20;

  typedef struct packed {
    logic [95:0]      tag;
    int               cyc;
    logic [N_CPU-1:0] dreq;
    logic             busy;
    logic             ah;
    logic             err;
    logic [N_CPU-1:0] late;
    logic [CNT_W-1:0] lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n, halt_req, resume_req;
  logic [N_CPU-1:0] cpu_mask, debugack, debugreq, late_mask;
  logic             busy, all_halted, timeout_err;
  logic [CNT_W-1:0] halt_latency;

  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  multi_cpu_debug_halt_ctrl #(
    .N_CPU       (N_CPU),
    .CNT_W       (CNT_W),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .halt_req     (halt_req),
    .resume_req   (resume_req),
    .cpu_mask     (cpu_mask),
    .debugack     (debugack),
    .debugreq     (debugreq),
    .busy         (busy),
    .all_halted   (all_halted),
    .timeout_err  (timeout_err),
    .late_mask    (late_mask),
    .halt_latency (halt_latency)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [CNT_W-1:0] lat_exp(input int v);
    return LAT_EN ? CNT_W'(v) : {CNT_W{1'b0}};
  endfunction

  task automatic expect_st(input logic [95:0] tag, input int ofs,
                           input logic [N_CPU-1:0] dreq, input logic bsy,
                           input logic ah, input logic err,
                           input logic [N_CPU-1:0] late, input logic [CNT_W-1:0] lat);
    exp_t e;
    e.tag = tag; e.cyc = cyc + ofs; e.dreq = dreq; e.busy = bsy;
    e.ah = ah; e.err = err; e.late = late; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compare every queued snapshot whose cycle has arrived.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        chk($sformatf("%0s.dreq", sb_q[i].tag), 32'(debugreq), 32'(sb_q[i].dreq));
        chk($sformatf("%0s.busy", sb_q[i].tag), 32'(busy), 32'(sb_q[i].busy));
        chk($sformatf("%0s.all_halted", sb_q[i].tag), 32'(all_halted), 32'(sb_q[i].ah));
        chk($sformatf("%0s.timeout_err", sb_q[i].tag), 32'(timeout_err), 32'(sb_q[i].err));
        chk($sformatf("%0s.late_mask", sb_q[i].tag), 32'(late_mask), 32'(sb_q[i].late));
        chk($sformatf("%0s.halt_latency", sb_q[i].tag), 32'(halt_latency), 32'(sb_q[i].lat));
        sb_q.delete(i);
      end else if (sb_q[i].cyc < cyc) begin
        chk($sformatf("%0s.missed", sb_q[i].tag), 32'd1, 32'd0);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
    cpu_mask = 4'h0; debugack = 4'h0;
    tick; tick;
    expect_st("rst", 0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, lat_exp(0));
    tick;
    reset_n = 1'b1;
    tick;

    // Full mask, staggered acks at wait cycles 3,5,7,9.
    cpu_mask = 4'hF; halt_req = 1'b1;
    expect_st("s1_r0", 1, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, lat_exp(0));
    expect_st("s1_r9", 10, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, lat_exp(0));
    expect_st("s1_r10", 11, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0, lat_exp(9));
    tick;
    halt_req = 1'b0; cpu_mask = 4'h0;
    for (int r = 0; r <= 10; r++) begin
      debugack = {r >= 9, r >= 7, r >= 5, r >= 3};
      tick;
    end

    // Resume from HALTED; acks drop two cycles after the request.
    resume_req = 1'b1;
    expect_st("s2_rw1", 1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, lat_exp(9));
    expect_st("s2_rw2", 2, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, lat_exp(9));
    expect_st("s2_idle", 3, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, lat_exp(9));
    tick;
    resume_req = 1'b0;
    tick;
    debugack = 4'h0;
    tick; tick;

    // Mask 0101, core2 never acks, core1 acks spuriously, halt dropped mid-wait.
    cpu_mask = 4'h5; halt_req = 1'b1;
    expect_st("s3_r0", 1, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, lat_exp(0));
    expect_st("s3_r19", 20, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, lat_exp(0));
    expect_st("s3_err", 21, 4'h1, 1'b0, 1'b0, 1'b1, 4'h4, lat_exp(TMO));
    tick;
    for (int r = 0; r <= 20; r++) begin
      debugack = (r >= 2) ? 4'h3 : 4'h0;
      halt_req = (r == 5);
      cpu_mask = (r == 5) ? 4'hF : 4'h0;
      tick;
    end
    halt_req = 1'b0; cpu_mask = 4'h0;

    // ERROR with halt and resume together: resume wins.
    halt_req = 1'b1; resume_req = 1'b1; cpu_mask = 4'hF;
    expect_st("s4_rw", 1, 4'h0, 1'b1, 1'b0, 1'b1, 4'h4, lat_exp(TMO));
    expect_st("s4_idle", 2, 4'h0, 1'b0, 1'b0, 1'b1, 4'h4, lat_exp(TMO));
    tick;
    halt_req = 1'b0; resume_req = 1'b0; cpu_mask = 4'h0; debugack = 4'h2;
    tick; tick;

    // IDLE with both requests and an empty mask: halt wins, straight to HALTED.
    halt_req = 1'b1; resume_req = 1'b1; cpu_mask = 4'h0;
    expect_st("s5_halted", 1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, lat_exp(0));
    tick;
    halt_req = 1'b0; resume_req = 1'b0;
    tick;

    // HALTED with both requests: resume wins, new mask ignored.
    halt_req = 1'b1; resume_req = 1'b1; cpu_mask = 4'hF;
    expect_st("s6_rw", 1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, lat_exp(0));
    expect_st("s6_idle", 2, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, lat_exp(0));
    tick;
    halt_req = 1'b0; resume_req = 1'b0; cpu_mask = 4'h0;
    tick; tick;

    // Immediate acks (latency 0), then core1 keeps acking through resume timeout.
    debugack = 4'h3; cpu_mask = 4'h3; halt_req = 1'b1;
    expect_st("s7_halted", 2, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, lat_exp(0));
    tick;
    halt_req = 1'b0; cpu_mask = 4'h0;
    tick;
    resume_req = 1'b1;
    expect_st("s7_r19", 20, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, lat_exp(0));
    expect_st("s7_tmo", 21, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2, lat_exp(0));
    tick;
    resume_req = 1'b0; debugack = 4'h2;
    repeat (21) tick;
    debugack = 4'h0;

    // Reset mid-wait takes effect without a clock edge.
    cpu_mask = 4'hF; halt_req = 1'b1;
    expect_st("s8_hw", 1, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, lat_exp(0));
    tick;
    halt_req = 1'b0; cpu_mask = 4'h0;
    tick; tick;
    #1;
    reset_n = 1'b0;
    expect_st("s8_async", 0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, lat_exp(0));
    tick; tick;
    reset_n = 1'b1;
    tick;
    debugack = 4'hA; cpu_mask = 4'hA; halt_req = 1'b1;
    expect_st("s8_r0", 1, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0, lat_exp(0));
    expect_st("s8_halted", 2, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0, lat_exp(0));
    tick;
    halt_req = 1'b0; cpu_mask = 4'h0;
    repeat (4) tick;

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_cpu_debug_halt_ctrl.md
Name: multi_cpu_debug_halt_ctrl

Overview:
Sequences coordinated halt/resume of the N Nios II cores in the parallel-processing system through each core's debug request/acknowledge pair, so host-side debug stops all processors within one controlled window. It sits in the system clock domain, between a host command source (CSR or JTAG-side logic) and the per-core debugreq/debugack signals. It latches a participation mask, watches for acknowledgements, and flags cores that miss a programmable timeout.

Parameters:
N_CPU, 4, number of cores controlled (1..16)
CNT_W, 12, width of timeout counter
ACK_TIMEOUT, 2000, cycles allowed for all masked acks (must be < 2**CNT_W)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
halt_req  in  1  single-cycle pulse: start halt of masked cores
resume_req  in  1  single-cycle pulse: release halted cores
cpu_mask  in  N_CPU  participating cores, sampled on accepted halt_req
debugack  in  N_CPU  per-core debug acknowledge (same clock domain)
debugreq  out  N_CPU  per-core debug request
busy  out  1  FSM not in IDLE/HALTED/ERROR
all_halted  out  1  every masked core acknowledged
timeout_err  out  1  sticky, cleared by next accepted halt_req
late_mask  out  N_CPU  masked cores without ack at timeout
halt_latency  out  CNT_W  cycles from halt start to all_halted (feature only)

Behaviour:
- Clock/reset: one clock, clk; reset_n asynchronous active-low, all state cleared immediately, released synchronously.
- Reset values: debugreq=0, busy=0, all_halted=0, timeout_err=0, late_mask=0, halt_latency=0, FSM=IDLE, latched mask=0, counter=0.
- States: IDLE, HALT_WAIT, HALTED, RESUME_WAIT, ERROR.
- IDLE: halt_req=1 -> latch cpu_mask, counter=0, clear timeout_err/late_mask, go HALT_WAIT. debugreq=latched mask from next cycle (1-cycle latency). resume_req ignored.
- halt_req with cpu_mask==0: go straight to HALTED, all_halted=1 next cycle, debugreq stays 0.
- HALT_WAIT: counter+1 per cycle. (debugack & mask)==mask -> HALTED, all_halted=1 the cycle after the condition. counter reaches ACK_TIMEOUT-1 without full ack -> ERROR, late_mask=mask & ~debugack, timeout_err=1. Ack and timeout in same cycle: ack wins.
- HALTED: debugreq held. resume_req -> RESUME_WAIT, debugreq=0 next cycle, all_halted=0, counter=0. halt_req ignored.
- ERROR: debugreq held for acked cores, dropped for late cores. resume_req -> RESUME_WAIT. halt_req -> restart as from IDLE (new mask).
- RESUME_WAIT: wait (debugack & mask)==0 -> IDLE. Timeout here -> IDLE with timeout_err=1, late_mask=cores still acking.
- halt_req and resume_req in same cycle: resume_req takes priority in HALTED/ERROR; halt_req takes priority in IDLE.
- Requests during HALT_WAIT/RESUME_WAIT dropped (no queueing); busy=1 indicates this.
- Counter saturates; never wraps.
- Spurious debugack of unmasked cores ignored in all states.

Optional Feature:
Macro HALT_LATENCY_STATS_EN. Defined: halt_latency captures counter value when HALT_WAIT->HALTED, holds until next accepted halt_req (which clears it to 0); on timeout it captures ACK_TIMEOUT. Undefined: halt_latency tied to 0, no capture register.

Decomposition:
- Shared package multi_cpu_debug_pkg: FSM state enum (3-bit), default ACK_TIMEOUT, N_CPU max constant.
- One sub-module natural: debug_ack_timeout_cnt (clear/enable/saturating counter with terminal flag), reused for halt and resume waits.

Test Plan:
- N_CPU=4, mask=4'b1111, acks arrive cycles 3,5,7,9 -> all_halted rises cycle 10, halt_latency=9, timeout_err=0.
- mask=4'b0101, core2 never acks, ACK_TIMEOUT=20 -> ERROR at cycle 20, late_mask=4'b0100, debugreq=4'b0001.
- From HALTED, resume_req with acks dropping 2 cycles later -> debugreq=0 next cycle, IDLE after acks low, all_halted=0.
- halt_req with mask=0 -> HALTED next cycle, debugreq=0, all_halted=1.
- reset_n asserted mid-HALT_WAIT -> debugreq=0 asynchronously, all outputs at reset values, next halt_req accepted normally.
- halt_req+resume_req same cycle in HALTED -> resume taken; in IDLE -> halt taken.
